ibex_csr_shadowed: RTL
======================

// Module: ibex_csr_shadowed
// PURPOSE
//   Parametrised CSR storage primitive for security-relevant registers (PMP, cpuctrl-class).
//   Generalises the plain 32-bit CSR flop: configurable width, reset value and writable-bit mask.
//   Optional two-step "double write" commit protocol.
//   Optional inverted shadow copy with continuous integrity checking and a sticky error flag.
//   Instantiated inside the CSR file; one instance per protected register.
// PARAMETERS
//   Width       32   data width in bits
//   ResetValue  '0   value of rd_data_o after reset (Width bits)
//   WriteMask   '1   1 = bit writable; 0 = bit held at ResetValue forever
//   ShadowCopy  1    1 = keep inverted shadow copy and check it; 0 = no shadow, no integrity check
//   DoubleWrite 1    1 = commit needs two matching writes; 0 = single write commits
// PORTS
//   clk_i          in   1      clock, rising edge
//   rst_i          in   1      asynchronous, active-high reset
//   wr_data_i      in   Width  write data
//   wr_en_i        in   1      write strobe, one write per cycle high
//   lock_i         in   1      1 = all writes ignored; aborts a staged write
//   err_clr_i      in   1      clear sticky integrity error
//   rd_data_o      out  Width  committed register value
//   wr_pend_o      out  1      first write of a double write is staged
//   wr_mismatch_o  out  1      one-cycle pulse: second write differs from staged data
//   rd_error_o     out  1      integrity error (live mismatch OR sticky flag)
// BEHAVIOUR
//   Reset (async, while rst_i high):
//     rdata_q = ResetValue, shadow_q = ~ResetValue, staged_q = 0, state = IDLE.
//     err_q = 0; wr_pend_o = 0, wr_mismatch_o = 0, rd_error_o = 0.
//   Masking: eff = (wr_data_i & WriteMask) | (ResetValue & ~WriteMask); all compares/commits use eff.
//   DoubleWrite=0: wr_en_i & !lock_i commits eff; visible on rd_data_o next cycle; FSM stays IDLE.
//   DoubleWrite=1, FSM {IDLE, STAGED}:
//     IDLE   : wr_en_i & !lock_i -> staged_q = eff, go STAGED; rdata_q unchanged.
//     STAGED : lock_i            -> discard staged data, go IDLE; no mismatch pulse; wins over wr_en_i.
//     STAGED : wr_en_i, eff == staged_q -> commit (rdata_q = eff, shadow_q = ~eff), go IDLE.
//     STAGED : wr_en_i, eff != staged_q -> no commit, wr_mismatch_o = 1 next cycle, go IDLE.
//     STAGED : no wr_en_i        -> hold indefinitely; no timeout.
//   wr_pend_o = (state == STAGED), registered; wr_mismatch_o is a registered single-cycle pulse.
//   Latency: commit visible on rd_data_o the cycle after the committing write edge.
//   Writes under lock_i: no state change, no pulse; rd_data_o unchanged.
//   Integrity (ShadowCopy=1):
//     live_err = (rdata_q != ~shadow_q), combinational.
//     err_q set on any cycle live_err = 1; cleared by err_clr_i.
//     Set wins over err_clr_i in the same cycle.
//     rd_error_o = live_err | err_q.
//     Error never blocks writes; a commit rewrites both copies consistently.
//   ShadowCopy=0: shadow logic absent; rd_error_o tied 0; err_clr_i ignored.
//   Reset mid-double-write: staged data lost; FSM returns to IDLE.
// TESTING (Width=32, ResetValue=32'h0000_0100, WriteMask=32'h0000_FFFF unless stated)
//   1. Release reset, no writes:
//      rd_data_o = 32'h0000_0100; wr_pend_o, wr_mismatch_o, rd_error_o all 0.
//   2. DoubleWrite=1: write 32'hDEAD_BEEF twice on consecutive cycles:
//      wr_pend_o = 1 after the first write; rd_data_o = 32'h0000_BEEF after the second; no mismatch.
//   3. Write 32'h1234, then 32'h1235:
//      wr_mismatch_o pulses exactly one cycle; rd_data_o stays 32'h0000_0100; wr_pend_o returns 0.
//   4. Write 32'h1234, assert lock_i one cycle, then write 32'h1234:
//      staged data discarded; the final write only stages (wr_pend_o = 1); rd_data_o unchanged.
//   5. Force shadow_q bit 3 flipped for one cycle:
//      rd_error_o = 1 and stays 1 after release.
//      err_clr_i together with a live error -> still 1.
//      err_clr_i alone -> 0 next cycle.
//   6. DoubleWrite=0, ShadowCopy=0: single write 32'hFFFF_FFFF -> rd_data_o = 32'h0000_FFFF next cycle.
//      Assert rst_i mid-run -> rd_data_o = 32'h0000_0100 immediately (asynchronous).

Source files
------------

// File: rtl/ibex_csr_shadowed_if.sv
// Write/read bundle for one protected CSR: write strobe, lock and error clear in; committed value and status out.
// The master drives the write side and the slave (the CSR primitive) drives the status side.
interface ibex_csr_shadowed_if #(
    parameter int Width = 32
);
    logic [Width-1:0] wr_data_i;
    logic             wr_en_i;
    logic             lock_i;
    logic             err_clr_i;
    logic [Width-1:0] rd_data_o;
    logic             wr_pend_o;
    logic             wr_mismatch_o;
    logic             rd_error_o;

    modport master (
        output wr_data_i, wr_en_i, lock_i, err_clr_i,
        input  rd_data_o, wr_pend_o, wr_mismatch_o, rd_error_o
    );

    modport slave (
        input  wr_data_i, wr_en_i, lock_i, err_clr_i,
        output rd_data_o, wr_pend_o, wr_mismatch_o, rd_error_o
    );
endinterface

// File: rtl/ibex_csr_shadowed.sv
// Protected CSR flop: masked writes, optional two-step matching-write commit, optional inverted shadow check.
// Commit is visible the cycle after the committing write; no backpressure, lock simply drops writes.
module ibex_csr_shadowed #(
    parameter int               Width       = 32,
    parameter logic [Width-1:0] ResetValue  = '0,
    parameter logic [Width-1:0] WriteMask   = '1,
    parameter bit               ShadowCopy  = 1'b1,
    parameter bit               DoubleWrite = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ibex_csr_shadowed_if.slave   bus
);
    typedef enum logic {S_IDLE, S_STAGED} state_e;

    state_e           r_state, w_state_nxt;
    logic [Width-1:0] r_rdata;
    logic [Width-1:0] r_staged, w_staged_nxt;
    logic [Width-1:0] w_eff;
    logic             r_mismatch, w_mismatch_nxt;
    logic             w_commit;

    // Read-only bits are pinned to their reset value before any compare or commit.
    assign w_eff = (bus.wr_data_i & WriteMask) | (ResetValue & ~WriteMask);

    always_comb begin
        w_state_nxt    = r_state;
        w_staged_nxt   = r_staged;
        w_commit       = 1'b0;
        w_mismatch_nxt = 1'b0;
        if (!DoubleWrite) begin
            w_state_nxt = S_IDLE;
            w_commit    = bus.wr_en_i & ~bus.lock_i;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_en_i && !bus.lock_i) begin
                        w_staged_nxt = w_eff;
                        w_state_nxt  = S_STAGED;
                    end
                end
                S_STAGED: begin
                    if (bus.lock_i) begin
                        w_staged_nxt = '0;
                        w_state_nxt  = S_IDLE;
                    end else if (bus.wr_en_i) begin
                        w_state_nxt  = S_IDLE;
                        w_staged_nxt = '0;
                        if (w_eff == r_staged) begin
                            w_commit = 1'b1;
                        end else begin
                            w_mismatch_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_rdata    <= ResetValue;
            r_staged   <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_staged   <= w_staged_nxt;
            r_mismatch <= w_mismatch_nxt;
            if (w_commit) begin
                r_rdata <= w_eff;
            end
        end
    end

    assign bus.rd_data_o     = r_rdata;
    assign bus.wr_pend_o     = (r_state == S_STAGED);
    assign bus.wr_mismatch_o = r_mismatch;

    generate
        if (ShadowCopy) begin : g_shadow
            logic [Width-1:0] r_shadow;
            logic             r_err;
            logic             w_live_err;

            assign w_live_err = (r_rdata != ~r_shadow);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_shadow <= ~ResetValue;
                end else if (w_commit) begin
                    r_shadow <= ~w_eff;
                end
            end

            // A live mismatch must win over a same-cycle clear so no error is ever lost.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_err <= 1'b0;
                end else if (w_live_err) begin
                    r_err <= 1'b1;
                end else if (bus.err_clr_i) begin
                    r_err <= 1'b0;
                end
            end

            assign bus.rd_error_o = w_live_err | r_err;
        end else begin : g_no_shadow
            logic w_unused_err_clr;
            assign w_unused_err_clr = bus.err_clr_i;
            assign bus.rd_error_o   = 1'b0;
        end
    endgenerate
endmodule
